// File: rtl/sbqm_pkg.sv
// -----------------------------------------------------------------------------
// sbqm_pkg
// Shared definitions for the single-bank queue slice: dispatcher FSM state
// encoding, queue/teller count widths and the queue occupancy limits.
// No ports (package).
// -----------------------------------------------------------------------------
package sbqm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CALL     = 2'd1,
        WAIT_ACK = 2'd2
    } dispState_t;

    localparam int PCOUNT_W = 3;
    localparam int TCOUNT_W = 2;

    localparam logic [PCOUNT_W-1:0] EMPTY = 3'd0;
    localparam logic [PCOUNT_W-1:0] FULL  = 3'd7;

endpackage

// File: rtl/teller_dispatch_if.sv
// -----------------------------------------------------------------------------
// teller_dispatch_if
// Signals between the queue counter side and the teller dispatcher.
//   pCount      queue occupancy seen by the dispatcher
//   emptyFlag   queue-empty flag from the queue counter
//   tCount      number of open tellers (0 = bank closed)
//   frontSensor one-cycle call pulse back to the queue counter
//   tellerBusy  per-teller busy flags
//   servedCount acknowledged dispatches (wrapping)
//   dispatchErr sticky unacknowledged-call flag
// Modports: master = dispatcher, slave = queue counter / observer.
// -----------------------------------------------------------------------------
interface teller_dispatch_if
    import sbqm_pkg::*;
#(
    parameter int MAX_TELLERS = 3,
    parameter int SERVED_W    = 8
);
    logic [PCOUNT_W-1:0]    pCount;
    logic                   emptyFlag;
    logic [TCOUNT_W-1:0]    tCount;
    logic                   frontSensor;
    logic [MAX_TELLERS-1:0] tellerBusy;
    logic [SERVED_W-1:0]    servedCount;
    logic                   dispatchErr;

    modport master (
        input  pCount, emptyFlag, tCount,
        output frontSensor, tellerBusy, servedCount, dispatchErr
    );

    modport slave (
        output pCount, emptyFlag, tCount,
        input  frontSensor, tellerBusy, servedCount, dispatchErr
    );
endinterface

// File: rtl/teller_timer.sv
// -----------------------------------------------------------------------------
// teller_timer
// Service-time down-counter for one teller. A load sets the count to
// SERVICE_CYCLES; afterwards it counts down by one per cycle until zero.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset, clears the count
//   load   start a new service period
//   busy   high while the count is nonzero
// -----------------------------------------------------------------------------
module teller_timer #(
    parameter int SERVICE_CYCLES = 12
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);
    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= 8'd0;
        end else if (load) begin
            count <= 8'(SERVICE_CYCLES);
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign busy = (count != 8'd0);
endmodule

// File: rtl/teller_dispatch.sv
// -----------------------------------------------------------------------------
// teller_dispatch
// Consumer end of the single-bank queue. Calls the front customer to a free
// open teller by pulsing frontSensor, then waits for the queue occupancy to
// drop as acknowledgement. Counts acknowledged dispatches and flags a sticky
// error when a call is never acknowledged.
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    teller_dispatch_if.master (pCount, emptyFlag, tCount in;
//          frontSensor, tellerBusy, servedCount, dispatchErr out)
// Optional build macro:
//   DISPATCH_ROUND_ROBIN_EN  round-robin teller selection starting at rrPtr;
//                            when undefined, lowest eligible index wins.
// -----------------------------------------------------------------------------
module teller_dispatch
    import sbqm_pkg::*;
#(
    parameter int MAX_TELLERS    = 3,
    parameter int SERVICE_CYCLES = 12,
    parameter int ACK_TIMEOUT    = 8,
    parameter int SERVED_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    teller_dispatch_if.master  bus
);
    localparam int IDX_W = (MAX_TELLERS > 1) ? $clog2(MAX_TELLERS) : 1;

    dispState_t             state;
    dispState_t             nextState;
    logic [MAX_TELLERS-1:0] busyVec;
    logic [MAX_TELLERS-1:0] eligible;
    logic [MAX_TELLERS-1:0] loadVec;
    logic [IDX_W-1:0]       pick;
    logic                   found;
    logic                   goCall;
    logic                   ackSeen;
    logic                   timedOut;
    logic                   callPulse;
    logic                   latchP;
    logic                   dispatchGo;
    logic [PCOUNT_W-1:0]    pLatch;
    logic [7:0]             ackCnt;
    logic [7:0]             ackNext;
    logic [SERVED_W-1:0]    servedCount;
    logic                   dispatchErr;

    // Teller service timers
    for (genvar i = 0; i < MAX_TELLERS; i++) begin : g_timer
        teller_timer #(.SERVICE_CYCLES(SERVICE_CYCLES)) u_timer (
            .clk   (clk),
            .reset (reset),
            .load  (loadVec[i]),
            .busy  (busyVec[i])
        );
    end

    // A teller beyond tCount may still be busy finishing; it is simply
    // never chosen again until tCount includes it.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < MAX_TELLERS; i++) begin
            eligible[i] = (i < int'(bus.tCount)) && !busyVec[i];
        end
    end

`ifdef DISPATCH_ROUND_ROBIN_EN
    logic [IDX_W-1:0] rrPtr;

    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < MAX_TELLERS; k++) begin
            idx = (int'(rrPtr) + k) % MAX_TELLERS;
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = IDX_W'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rrPtr <= '0;
        end else if (dispatchGo) begin
            rrPtr <= IDX_W'((int'(pick) + 1) % MAX_TELLERS);
        end
    end
`else
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = MAX_TELLERS - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found = 1'b1;
                pick  = IDX_W'(i);
            end
        end
    end
`endif

    assign goCall   = (bus.pCount != EMPTY) && !bus.emptyFlag && found;
    assign ackNext  = ackCnt + 8'd1;
    assign ackSeen  = (state == WAIT_ACK) && (bus.pCount < pLatch);
    assign timedOut = (state == WAIT_ACK) && !ackSeen && (ackNext == 8'(ACK_TIMEOUT));

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next state
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE:     if (goCall) nextState = CALL;
            CALL:     nextState = WAIT_ACK;
            WAIT_ACK: if (ackSeen || timedOut) nextState = IDLE;
            default:  nextState = IDLE;
        endcase
    end

    // FSM outputs. The timer is loaded on the edge that enters CALL so the
    // teller already reads busy during the CALL cycle itself.
    always_comb begin
        callPulse  = 1'b0;
        latchP     = 1'b0;
        dispatchGo = 1'b0;
        unique case (state)
            IDLE:     dispatchGo = goCall;
            CALL: begin
                callPulse = 1'b1;
                latchP    = 1'b1;
            end
            WAIT_ACK: ;
            default:  ;
        endcase
    end

    always_comb begin
        loadVec = '0;
        if (dispatchGo) loadVec[pick] = 1'b1;
    end

    // Acknowledge tracking and statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            pLatch      <= '0;
            ackCnt      <= 8'd0;
            servedCount <= '0;
            dispatchErr <= 1'b0;
        end else begin
            if (latchP) begin
                pLatch <= bus.pCount;
                ackCnt <= 8'd0;
            end else if ((state == WAIT_ACK) && !ackSeen) begin
                ackCnt <= ackNext;
            end
            if (ackSeen)  servedCount <= servedCount + 1'b1;
            if (timedOut) dispatchErr <= 1'b1;
        end
    end

    // Reset kills an in-flight pulse immediately so the queue never counts it.
    assign bus.frontSensor = callPulse && !reset;
    assign bus.tellerBusy  = busyVec;
    assign bus.servedCount = servedCount;
    assign bus.dispatchErr = dispatchErr;
endmodule

// File: tb/tb_teller_dispatch.sv
module tb_teller_dispatch;
    import sbqm_pkg::*;

    localparam int NT    = 3;
    localparam int SVC   = 12;
    localparam int ACKTO = 8;
    localparam int SW    = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    teller_dispatch_if #(.MAX_TELLERS(NT), .SERVED_W(SW)) tdIf ();

    teller_dispatch #(
        .MAX_TELLERS(NT), .SERVICE_CYCLES(SVC), .ACK_TIMEOUT(ACKTO), .SERVED_W(SW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tdIf)
    );

    int checks   = 0;
    int failures = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: remaining service time per teller, plus where the single
    // outstanding call is (0 none, 1 calling now, 2 awaiting queue drop).
    int mPhase, mServed, mErr, mLatch, mWaited, mRr;
    int mBusy[NT];

    // Queue environment
    int  p;
    int  tc;
    int  decPct, arrPct;
    bit  sawPulse;

    task automatic modelReset();
        mPhase = 0; mServed = 0; mErr = 0; mLatch = 0; mWaited = 0; mRr = 0;
        for (int k = 0; k < NT; k++) mBusy[k] = 0;
    endtask

    task automatic modelStep();
        int pick, start;
        if (reset) begin
            modelReset();
            return;
        end
        pick = -1;
`ifdef DISPATCH_ROUND_ROBIN_EN
        start = mRr;
`else
        start = 0;
`endif
        if (mPhase == 0 && tdIf.pCount != 0 && !tdIf.emptyFlag) begin
            for (int k = 0; k < NT; k++) begin
                int t;
                t = (start + k) % NT;
                if (pick < 0 && t < int'(tdIf.tCount) && mBusy[t] == 0) pick = t;
            end
        end
        for (int k = 0; k < NT; k++) if (mBusy[k] > 0) mBusy[k]--;
        case (mPhase)
            0: if (pick >= 0) begin
                   mBusy[pick] = SVC;
                   mPhase = 1;
                   mRr = (pick + 1) % NT;
               end
            1: begin
                   mLatch = int'(tdIf.pCount);
                   mWaited = 0;
                   mPhase = 2;
               end
            default: begin
                   if (int'(tdIf.pCount) < mLatch) begin
                       mServed = (mServed + 1) % (1 << SW);
                       mPhase = 0;
                   end else begin
                       mWaited++;
                       if (mWaited == ACKTO) begin
                           mErr = 1;
                           mPhase = 0;
                       end
                   end
               end
        endcase
    endtask

    task automatic applyInputs();
        tdIf.pCount    = PCOUNT_W'(p);
        tdIf.emptyFlag = (PCOUNT_W'(p) == EMPTY);
        tdIf.tCount    = TCOUNT_W'(tc);
    endtask

    task automatic cycle(input bit doCheck);
        logic [NT-1:0] expBusy;
        @(negedge clk);
        sawPulse = tdIf.frontSensor;
        if (doCheck) begin
            for (int k = 0; k < NT; k++) expBusy[k] = (mBusy[k] > 0);
            checkVal("frontSensor", 32'(tdIf.frontSensor), 32'(mPhase == 1 && !reset));
            checkVal("tellerBusy",  32'(tdIf.tellerBusy),  32'(expBusy));
            checkVal("servedCount", 32'(tdIf.servedCount), 32'(mServed));
            checkVal("dispatchErr", 32'(tdIf.dispatchErr), 32'(mErr));
        end
        modelStep();
        @(posedge clk);
        #1;
        // Queue counter reacts one cycle after a pulse; arrivals are random.
        if (sawPulse && p > int'(EMPTY) && $urandom_range(99) < decPct) p--;
        if ($urandom_range(99) < arrPct && p < int'(FULL)) p++;
        applyInputs();
    endtask

    task automatic resetCycle();
        reset = 1'b1;
        cycle(1'b1);
        reset = 1'b0;
    endtask

    task automatic runSeg(input int n, input int tChgPct, input int rstPerMil);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(99) < tChgPct) begin
                tc = $urandom_range(3);
                applyInputs();
            end
            reset = ($urandom_range(999) < rstPerMil);
            cycle(1'b1);
        end
        reset = 1'b0;
    endtask

    initial begin
        modelReset();
        reset = 1'b1; p = 3; tc = 1; decPct = 100; arrPct = 0;
        applyInputs();
        @(posedge clk); #1;
        cycle(1'b0);
        cycle(1'b1);
        reset = 1'b0;
        // First cycle after release: idle, pulse on the following one.
        cycle(1'b1);
        checkVal("noPulseFirst", 32'(sawPulse), 32'd0);
        cycle(1'b1);
        checkVal("pulseSecond", 32'(sawPulse), 32'd1);
        runSeg(40, 0, 0);

        // Single teller, two customers
        resetCycle(); p = 2; tc = 1; decPct = 100; arrPct = 0; applyInputs();
        runSeg(60, 0, 0);

        // Three tellers fill up back to back
        resetCycle(); p = 5; tc = 3; applyInputs();
        runSeg(60, 0, 0);

        // No acknowledge: timeout
        resetCycle(); p = 4; tc = 2; decPct = 0; applyInputs();
        runSeg(40, 0, 0);
        checkVal("errSticky", 32'(tdIf.dispatchErr), 32'd1);
        checkVal("servedZero", 32'(tdIf.servedCount), 32'd0);

        // Shrink tCount while tellers busy, then close the bank
        resetCycle(); p = 7; tc = 3; decPct = 100; applyInputs();
        runSeg(8, 0, 0);
        tc = 1; arrPct = 20; applyInputs();
        runSeg(60, 0, 0);
        tc = 0; applyInputs();
        runSeg(30, 0, 0);

        // Randomised mix with missed acks, tCount changes and resets
        resetCycle(); decPct = 90; arrPct = 35; tc = 3; applyInputs();
        runSeg(3000, 3, 2);

        // Long busy run so servedCount wraps
        resetCycle(); decPct = 100; arrPct = 60; tc = 3; p = 7; applyInputs();
        runSeg(2500, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
